// File: rtl/qproc_in_port_fifo.sv
`default_nettype none
// ============================================================================
// Module   : qproc_in_port_fifo
// Brief    : Per-port input FIFOs feeding the core's 64-bit input port bus.
// Revision : 1.0
// ============================================================================
module qproc_in_port_fifo #(
    parameter int IN_PORT_QTY = 4,
    parameter int PORT_AW     = 4,
    parameter int FIFO_AW     = 3
) (
    input  logic                                c_clk_i,
    input  logic                                c_rst_ni,
    input  logic                                restart_i,
    input  logic [IN_PORT_QTY-1:0]              in_vld_i,
    input  logic [IN_PORT_QTY-1:0][63:0]        in_dt_i,
    input  logic                                pop_i,
    input  logic [PORT_AW-1:0]                  pop_addr_i,
    input  logic [PORT_AW-1:0]                  flag_sel_i,
    output logic [IN_PORT_QTY-1:0][63:0]        port_dt_o,
    output logic [IN_PORT_QTY-1:0]              port_new_o,
    output logic                                flag_o,
    output logic [IN_PORT_QTY-1:0]              ovf_o,
    output logic [IN_PORT_QTY-1:0][FIFO_AW:0]   occ_o
);

    localparam int             C_DEPTH   = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] C_PTR_ONE = 1;

    logic [IN_PORT_QTY-1:0] w_flag_hit;

    generate
        for (genvar i = 0; i < IN_PORT_QTY; i++) begin : g_port
            logic [FIFO_AW:0] r_wr_ptr;
            logic [FIFO_AW:0] r_rd_ptr;
            logic             r_ovf;
            logic [63:0]      r_mem [C_DEPTH];
            logic             w_empty;
            logic             w_full;
            logic             w_pop;
            logic             w_push;
            logic             w_drop;

            assign w_empty = (r_wr_ptr == r_rd_ptr);
            assign w_full  = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                             (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
            // Out-of-range pop addresses never match any port, so they are ignored.
            assign w_pop   = pop_i && (pop_addr_i == PORT_AW'(i)) && !w_empty;
            // A pop on a full FIFO frees the slot the push lands in.
            assign w_push  = in_vld_i[i] && (!w_full || w_pop) && !restart_i;
            assign w_drop  = in_vld_i[i] && w_full && !w_pop;

            always_ff @(posedge c_clk_i) begin
                if (w_push) begin
                    r_mem[r_wr_ptr[FIFO_AW-1:0]] <= in_dt_i[i];
                end
            end

            always_ff @(posedge c_clk_i or negedge c_rst_ni) begin
                if (!c_rst_ni) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_ovf    <= 1'b0;
                end else if (restart_i) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_ovf    <= 1'b0;
                end else begin
                    if (w_push) begin
                        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
                    end
                    if (w_pop) begin
                        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
                    end
                    if (w_drop) begin
                        r_ovf <= 1'b1;
                    end
                end
            end

            assign port_dt_o[i]  = w_empty ? 64'd0 : r_mem[r_rd_ptr[FIFO_AW-1:0]];
            assign port_new_o[i] = !w_empty;
            assign ovf_o[i]      = r_ovf;
            assign occ_o[i]      = r_wr_ptr - r_rd_ptr;
            assign w_flag_hit[i] = (flag_sel_i == PORT_AW'(i)) && !w_empty;
        end
    endgenerate

    assign flag_o = |w_flag_hit;

endmodule
`default_nettype wire
